sram_like_responder: RTL

- Responder (slave) end of the core's SRAM-like bus (req/wr/size/wstrb/addr/wdata -> addr_ok/data_ok/rdata).
- Backed by an internal word-addressed RAM.
- Accepts pipelined requests, queues up to DEPTH outstanding transactions, and returns data_ok strictly in request order after a programmable minimum latency.
- Used as the inst-side and data-side memory model in core-level simulation, and as the slave-side template for the later AXI bridge.

---
 rtl/sram_like_responder.sv | 109 ++++++++++
 1 files changed

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like bus: word-addressed RAM behind an in-order
// response queue that answers each accepted request exactly LAT cycles later.

module sram_like_responder #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WORDS = 1 << ADDR_W;
  localparam logic [3:0] CD_INIT = 4'(LAT - 1);

  logic [31:0]       r_mem [WORDS];
  logic [31:0]       r_data [DEPTH];
  logic [3:0]        r_cd [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_headReady;
  logic [ADDR_W-1:0] w_idx;
  logic              w_unused;

  // size is informational only and the byte offset / upper address bits
  // never reach the RAM index.
  assign w_unused = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  assign w_idx   = addr[ADDR_W+1:2];
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign addr_ok = !w_full && !stall && !reset;
  assign w_push  = req && addr_ok;

  // Responses are decoded purely from queue registers, so a request accepted
  // in cycle C surfaces in cycle C+LAT and the head retires while data_ok shows.
  assign w_headReady = r_valid[r_head] && (r_cd[r_head] == 4'd0);
  assign data_ok     = w_headReady && !reset;
  assign w_pop       = data_ok;
  assign rdata       = data_ok ? r_data[r_head] : 32'd0;

  always_ff @(posedge clk) begin
    if (w_push && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Write responses carry zero so the output mux needs no wr flag.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_tail] <= wr ? 32'd0 : r_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_cd[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && (r_cd[i] != 4'd0)) begin
          r_cd[i] <= r_cd[i] - 4'd1;
        end
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      // Pushing is blocked when full, so the tail never aliases a live head.
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_cd[r_tail]    <= CD_INIT;
        r_tail          <= r_tail + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
